alu_8bit: RTL and testbench



---
 rtl/alu_8bit.sv | 87 ++++++++
 tb/tb_alu_8bit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_8bit.sv
// Registered 8-bit ALU with zero/carry flags and a one-bit valid pipeline.
// Optional ROL/ROR/INC/DEC/NAND on codes 1011-1111 when ALU_8BIT_EXT_OPS_EN is defined.
module alu_8bit (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic [3:0] ALU_Sel,
   output logic [7:0] ALU_Out,
   output logic       Zero,
   output logic       Carryout,
   output logic       out_valid
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_NOT  = 4'b0101;
   localparam logic [3:0] OP_SHL  = 4'b0110;
   localparam logic [3:0] OP_SHR  = 4'b0111;
   localparam logic [3:0] OP_EQ   = 4'b1000;
   localparam logic [3:0] OP_GT   = 4'b1001;
   localparam logic [3:0] OP_LT   = 4'b1010;
`ifdef ALU_8BIT_EXT_OPS_EN
   localparam logic [3:0] OP_ROL  = 4'b1011;
   localparam logic [3:0] OP_ROR  = 4'b1100;
   localparam logic [3:0] OP_INC  = 4'b1101;
   localparam logic [3:0] OP_DEC  = 4'b1110;
   localparam logic [3:0] OP_NAND = 4'b1111;
`endif

   logic [7:0] res;
   logic       carry;

   // Valid semantics: in_valid qualifies A/B/ALU_Sel at an edge; out_valid is
   // high for exactly the cycle after each such edge. There is no ready/backpressure.
   always_comb begin
      res   = 8'h00;
      carry = 1'b0;
      case (ALU_Sel)
         // 9-bit arithmetic: bit 8 is carry for add, borrow for subtract.
         OP_ADD:  {carry, res} = {1'b0, A} + {1'b0, B};
         OP_SUB:  {carry, res} = {1'b0, A} - {1'b0, B};
         OP_AND:  res = A & B;
         OP_OR:   res = A | B;
         OP_XOR:  res = A ^ B;
         OP_NOT:  res = ~A;
         OP_SHL:  {carry, res} = {A, 1'b0};
         OP_SHR:  {res, carry} = {1'b0, A};
         OP_EQ:   res = {7'd0, (A == B)};
         OP_GT:   res = {7'd0, (A > B)};
         OP_LT:   res = {7'd0, (A < B)};
`ifdef ALU_8BIT_EXT_OPS_EN
         OP_ROL:  begin res = {A[6:0], A[7]}; carry = A[7]; end
         OP_ROR:  begin res = {A[0], A[7:1]}; carry = A[0]; end
         OP_INC:  {carry, res} = {1'b0, A} + 9'd1;
         OP_DEC:  {carry, res} = {1'b0, A} - 9'd1;
         OP_NAND: res = ~(A & B);
`endif
         default: begin
            res   = 8'h00;
            carry = 1'b0;
         end
      endcase
   end

   // Result registers hold when no new operation arrives; only valid drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         ALU_Out   <= 8'h00;
         Zero      <= 1'b1;
         Carryout  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            ALU_Out  <= res;
            Zero     <= (res == 8'h00);
            Carryout <= carry;
         end
      end
   end

endmodule

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit: directed table plus random stimulus
// against an arithmetic reference model (honours ALU_8BIT_EXT_OPS_EN).
module tb_alu_8bit;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] A, B;
   logic [3:0] ALU_Sel;
   logic [7:0] ALU_Out;
   logic       Zero, Carryout, out_valid;

   int tests_run = 0;
   int fails     = 0;

   // Model of the registered outputs.
   logic [7:0] exp_out;
   logic       exp_z, exp_c, exp_v;

   alu_8bit dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .ALU_Sel(ALU_Sel),
      .ALU_Out(ALU_Out), .Zero(Zero), .Carryout(Carryout), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   // Reference computed with plain integer arithmetic; returns {c, r}.
   function automatic logic [8:0] ref_alu(input int a, input int b, input int sel);
      int r, c;
      r = 0; c = 0;
      case (sel)
         0: begin r = (a + b) % 256; c = (a + b) > 255; end
         1: begin r = (a - b + 256) % 256; c = a < b; end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = 255 - a;
         6: begin r = (a * 2) % 256; c = a >= 128; end
         7: begin r = a / 2; c = a % 2; end
         8: r = (a == b) ? 1 : 0;
         9: r = (a > b) ? 1 : 0;
         10: r = (a < b) ? 1 : 0;
`ifdef ALU_8BIT_EXT_OPS_EN
         11: begin r = (a * 2) % 256 + a / 128; c = a >= 128; end
         12: begin r = a / 2 + (a % 2) * 128; c = a % 2; end
         13: begin r = (a + 1) % 256; c = a == 255; end
         14: begin r = (a + 255) % 256; c = a == 0; end
         15: r = 255 - (a & b);
`endif
         default: begin r = 0; c = 0; end
      endcase
      return {c[0], r[7:0]};
   endfunction

   task automatic check_outputs(input string tag);
      tests_run++;
      assert (ALU_Out === exp_out) else begin
         fails++;
         $error("FAIL %s ALU_Out got %h expected %h", tag, ALU_Out, exp_out);
      end
      tests_run++;
      assert (Zero === exp_z) else begin
         fails++;
         $error("FAIL %s Zero got %b expected %b", tag, Zero, exp_z);
      end
      tests_run++;
      assert (Carryout === exp_c) else begin
         fails++;
         $error("FAIL %s Carryout got %b expected %b", tag, Carryout, exp_c);
      end
      tests_run++;
      assert (out_valid === exp_v) else begin
         fails++;
         $error("FAIL %s out_valid got %b expected %b", tag, out_valid, exp_v);
      end
   endtask

   // Drive one cycle of inputs, advance the model, then check after the edge.
   task automatic step(input logic r, input logic v, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] sel, input string tag);
      logic [8:0] m;
      @(negedge clk);
      rst = r; in_valid = v; A = a; B = b; ALU_Sel = sel;
      @(posedge clk);
      if (r) begin
         exp_out = 8'h00; exp_z = 1'b1; exp_c = 1'b0; exp_v = 1'b0;
      end else begin
         exp_v = v;
         if (v) begin
            m = ref_alu(int'(a), int'(b), int'(sel));
            exp_out = m[7:0];
            exp_c   = m[8];
            exp_z   = (m[7:0] == 8'h00);
         end
      end
      #1;
      check_outputs(tag);
   endtask

   // Directed expectations for A=0A, B=05 across selects 0..10: {out, c, z}.
   logic [9:0] sweep_exp [0:10];
   logic [9:0] se;

   initial begin
      sweep_exp[0]  = {8'h0F, 1'b0, 1'b0};
      sweep_exp[1]  = {8'h05, 1'b0, 1'b0};
      sweep_exp[2]  = {8'h00, 1'b0, 1'b1};
      sweep_exp[3]  = {8'h0F, 1'b0, 1'b0};
      sweep_exp[4]  = {8'h0F, 1'b0, 1'b0};
      sweep_exp[5]  = {8'hF5, 1'b0, 1'b0};
      sweep_exp[6]  = {8'h14, 1'b0, 1'b0};
      sweep_exp[7]  = {8'h05, 1'b0, 1'b0};
      sweep_exp[8]  = {8'h00, 1'b0, 1'b1};
      sweep_exp[9]  = {8'h01, 1'b0, 1'b0};
      sweep_exp[10] = {8'h00, 1'b0, 1'b1};

      rst = 1'b1; in_valid = 1'b0; A = 8'h00; B = 8'h00; ALU_Sel = 4'h0;
      exp_out = 8'h00; exp_z = 1'b1; exp_c = 1'b0; exp_v = 1'b0;

      // Reset for two cycles
      step(1'b1, 1'b0, 8'h00, 8'h00, 4'h0, "reset1");
      step(1'b1, 1'b1, 8'h12, 8'h34, 4'h0, "reset2_priority");

      // Sweep with in_valid high every cycle, plus hand-derived table check
      for (int s = 0; s <= 10; s++) begin
         step(1'b0, 1'b1, 8'h0A, 8'h05, 4'(s), "sweep");
         se = sweep_exp[s];
         tests_run++;
         assert ({ALU_Out, Carryout, Zero} === se) else begin
            fails++;
            $error("FAIL sweep_table sel=%0d got %h/%b/%b expected %h/%b/%b",
                   s, ALU_Out, Carryout, Zero, se[9:2], se[1], se[0]);
         end
      end

      // Carry, borrow and shifted-out bits
      step(1'b0, 1'b1, 8'hFF, 8'h01, 4'b0000, "add_carry");
      tests_run++;
      assert ({ALU_Out, Carryout, Zero} === {8'h00, 1'b1, 1'b1}) else begin
         fails++; $error("FAIL add_carry_const got %h/%b/%b expected 00/1/1", ALU_Out, Carryout, Zero);
      end
      step(1'b0, 1'b1, 8'h05, 8'h0A, 4'b0001, "sub_borrow");
      tests_run++;
      assert ({ALU_Out, Carryout} === {8'hFB, 1'b1}) else begin
         fails++; $error("FAIL sub_borrow_const got %h/%b expected FB/1", ALU_Out, Carryout);
      end
      step(1'b0, 1'b1, 8'h80, 8'h00, 4'b0110, "shl_out");
      step(1'b0, 1'b1, 8'h01, 8'h00, 4'b0111, "shr_out");
      step(1'b0, 1'b1, 8'h00, 8'h00, 4'b0000, "zero_add");

      // Hold: ADD then three idle cycles with changing operands
      step(1'b0, 1'b1, 8'h21, 8'h13, 4'b0000, "hold_add");
      step(1'b0, 1'b0, 8'hFF, 8'hFF, 4'b0001, "hold1");
      step(1'b0, 1'b0, 8'h00, 8'h80, 4'b0101, "hold2");
      step(1'b0, 1'b0, 8'h7E, 8'h01, 4'b0110, "hold3");
      tests_run++;
      assert (ALU_Out === 8'h34) else begin
         fails++; $error("FAIL hold_const got %h expected 34", ALU_Out);
      end
      // Mid-stream reset discards the in-flight op
      step(1'b0, 1'b1, 8'h05, 8'h06, 4'b0000, "pre_rst");
      step(1'b1, 1'b1, 8'h40, 8'h40, 4'b0000, "mid_rst");
      step(1'b0, 1'b0, 8'h40, 8'h40, 4'b0000, "post_rst_idle");

      // Select 1011 with A=81
      step(1'b0, 1'b1, 8'h81, 8'h00, 4'b1011, "sel_1011");
      tests_run++;
`ifdef ALU_8BIT_EXT_OPS_EN
      assert ({ALU_Out, Carryout, Zero} === {8'h03, 1'b1, 1'b0}) else begin
         fails++; $error("FAIL sel_1011_const got %h/%b/%b expected 03/1/0", ALU_Out, Carryout, Zero);
      end
`else
      assert ({ALU_Out, Carryout, Zero} === {8'h00, 1'b0, 1'b1}) else begin
         fails++; $error("FAIL sel_1011_const got %h/%b/%b expected 00/0/1", ALU_Out, Carryout, Zero);
      end
`endif
      for (int s = 11; s <= 15; s++)
         step(1'b0, 1'b1, 8'h00, 8'h5A, 4'(s), "upper_codes_a0");

      // Random stimulus: mostly valid, occasional idle and reset
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              4'($urandom_range(0, 15)), "random");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
